// File: rtl/cs_request_throttle.sv
// cs_request_throttle
//   Single-entry request register between the CS bridge and the timeout/mux
//   stage. It caps the number of issued-but-unanswered requests at
//   MAX_OUTSTANDING by stalling the bridge, and raises sticky flags for
//   completion underflow and simultaneous read/write commands.
//
// Ports
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   hps_*_i / hps_waitrequest_o   request side from the CS bridge
//   cs_*_o / cs_waitrequest_i     registered request toward the timeout/mux stage
//   rsp_readdatavalid_i, rsp_writerespvalid_i   completions, one per pulse
//   err_clr_i                 clears the sticky error flags
//   outstanding_o             issued-but-unanswered count
//   rsp_underflow_err_o, proto_err_o   sticky error flags
module cs_request_throttle #(
  parameter int unsigned ADDR_WIDTH      = 14,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [ADDR_WIDTH-1:0]   hps_address_i,
  input  logic [DATA_WIDTH-1:0]   hps_writedata_i,
  input  logic [DATA_WIDTH/8-1:0] hps_byteenable_i,
  input  logic                    hps_read_i,
  input  logic                    hps_write_i,
  output logic                    hps_waitrequest_o,
  output logic [ADDR_WIDTH-1:0]   cs_address_o,
  output logic [DATA_WIDTH-1:0]   cs_writedata_o,
  output logic [DATA_WIDTH/8-1:0] cs_byteenable_o,
  output logic                    cs_read_o,
  output logic                    cs_write_o,
  input  logic                    cs_waitrequest_i,
  input  logic                    rsp_readdatavalid_i,
  input  logic                    rsp_writerespvalid_i,
  input  logic                    err_clr_i,
  output logic [CNT_WIDTH-1:0]    outstanding_o,
  output logic                    rsp_underflow_err_o,
  output logic                    proto_err_o
);

  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  // Wide enough for count + pending entry + two completions without wrap.
  localparam int unsigned SumWidth = CNT_WIDTH + 2;
  localparam logic [SumWidth-1:0] MaxOcc = SumWidth'(MAX_OUTSTANDING);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BeWidth-1:0]    be_q, be_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  uf_q, uf_d;
  logic                  pe_q, pe_d;

  logic                  full;
  logic                  accept;
  logic                  issue;
  logic                  underflow_ev;
  logic                  proto_ev;
  logic [SumWidth-1:0]   occupancy;
  logic [SumWidth-1:0]   cnt_plus_issue;
  logic [SumWidth-1:0]   dec;

  assign full = (state_q == StFull);

  // Occupancy counts the held entry as already outstanding so the cap holds
  // once it issues.
  assign occupancy = SumWidth'(cnt_q) + SumWidth'(full);
  assign hps_waitrequest_o = ~rstn_i | full | (occupancy >= MaxOcc);

  assign accept = (hps_read_i | hps_write_i) & ~hps_waitrequest_o;
  assign issue  = full & (rd_q | wr_q) & ~cs_waitrequest_i;

  // Completions are measured against the count after any same-cycle issue.
  assign cnt_plus_issue = SumWidth'(cnt_q) + SumWidth'(issue);
  assign dec            = SumWidth'(rsp_readdatavalid_i) + SumWidth'(rsp_writerespvalid_i);
  assign underflow_ev   = (dec > cnt_plus_issue);
  assign proto_ev       = accept & hps_read_i & hps_write_i;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;

    if (issue) begin
      state_d = StEmpty;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end
    // Accept cannot coincide with issue: waitrequest is high while FULL.
    if (accept) begin
      state_d = StFull;
      rd_d    = hps_read_i;
      wr_d    = hps_write_i & ~hps_read_i;
      addr_d  = hps_address_i;
      data_d  = hps_writedata_i;
      be_d    = hps_byteenable_i;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (underflow_ev) begin
      cnt_d = '0;
    end else begin
      cnt_d = CNT_WIDTH'(cnt_plus_issue - dec);
    end
  end

  // Error events win over a same-cycle clear.
  always_comb begin
    uf_d = uf_q;
    pe_d = pe_q;
    if (underflow_ev) begin
      uf_d = 1'b1;
    end else if (err_clr_i) begin
      uf_d = 1'b0;
    end
    if (proto_ev) begin
      pe_d = 1'b1;
    end else if (err_clr_i) begin
      pe_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StEmpty;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      uf_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
      pe_q    <= pe_d;
    end
  end

  assign cs_address_o        = addr_q;
  assign cs_writedata_o      = data_q;
  assign cs_byteenable_o     = be_q;
  assign cs_read_o           = rd_q;
  assign cs_write_o          = wr_q;
  assign outstanding_o       = cnt_q;
  assign rsp_underflow_err_o = uf_q;
  assign proto_err_o         = pe_q;

endmodule
